lspc_vram_cpu_port: RTL
=======================

// Module: lspc_vram_cpu_port
// PURPOSE
//  CPU-side initiator for the LSPC VRAM ports; owns REG_VRAMADDR, REG_VRAMRW and REG_VRAMMOD.
//  Issues write requests to the slow (low) and fast (high) VRAM cycle engines and collects their acks.
//  Applies the auto-increment and keeps a prefetched read word for VRAMRW reads.
//  Sits between the 68k register decode and the slow/fast cycle blocks.
// PARAMETERS
//  PRESERVE_MSB  1   1: address bit 15 (bank select) is held during auto-increment; 0: full 16-bit add
//  RST_MOD       1   reset value of REG_VRAMMOD
// PORTS
//  CLK             in   1   system clock
//  RESETP          in   1   reset, asynchronous, active-low
//  CPU_WR_STB      in   1   1-CLK pulse: CPU register write (already synchronised and decoded)
//  CPU_RD_STB      in   1   1-CLK pulse: CPU register read
//  CPU_REG         in   2   0=VRAMADDR, 1=VRAMRW, 2=VRAMMOD, 3=ignored
//  CPU_DIN         in   16  CPU write data
//  CPU_DOUT        out  16  read data: reg1 -> prefetch, reg2 -> modulo, others -> 16'h0000
//  nVRAM_WRITE_REQ out  1   low while a CPU write is pending
//  VRAM_ADDR       out  16  current VRAM address
//  VRAM_WRITE      out  16  latched write data
//  REG_VRAMADDR_MSB out 1   VRAM_ADDR[15]; 1 = fast/high VRAM target
//  nCPU_WR_HIGH    in   1   from fast cycle: low for one slot when a high write is taken
//  nCPU_WR_LOW     in   1   from slow cycle: low for one slot when a low write is taken
//  RD_HIGH_STB     in   1   1-CLK pulse: VRAM_HIGH_READ is valid for the current address
//  RD_LOW_STB      in   1   1-CLK pulse: VRAM_LOW_READ is valid for the current address
//  VRAM_HIGH_READ  in   16  fast VRAM read word
//  VRAM_LOW_READ   in   16  slow VRAM read word
//  BUSY            out  1   FSM is not in IDLE
// BEHAVIOUR
//  Reset values:
//   - VRAM_ADDR=0, VRAM_WRITE=0, MOD=RST_MOD, prefetch=0.
//   - nVRAM_WRITE_REQ=1, BUSY=0, CPU_DOUT=0, FSM=IDLE.
//  FSM states:
//   - IDLE: no request outstanding.
//     - reg1 write -> latch data, enter WR_WAIT.
//     - reg0 write -> load address, enter RD_WAIT.
//   - WR_WAIT: nVRAM_WRITE_REQ=0.
//     - Ack = falling edge of nCPU_WR_HIGH if MSB=1, of nCPU_WR_LOW if MSB=0.
//     - On ack: drop request, go to INC.
//   - INC: exactly one CLK.
//     - PRESERVE_MSB=1: ADDR <= {ADDR[15], ADDR[14:0]+MOD[14:0]}, mod-2^15 wrap.
//     - PRESERVE_MSB=0: ADDR <= ADDR+MOD, mod-2^16 wrap.
//     - Then go to RD_WAIT.
//   - RD_WAIT: wait for the strobe matching MSB.
//     - On strobe: prefetch <= HIGH/LOW read word, return to IDLE.
//  Request timing:
//   - nVRAM_WRITE_REQ goes low 1 CLK after CPU_WR_STB.
//   - It goes high the CLK after the ack edge is detected.
//   - The ack input is registered once for edge detection. An edge already present when WR_WAIT is entered does not count.
//  Collisions:
//   - reg1 write in WR_WAIT: replace VRAM_WRITE; stay in WR_WAIT; single increment.
//   - reg1 write in INC or RD_WAIT: latch data, go to WR_WAIT. The write uses the post-increment address. An unfinished prefetch is abandoned.
//   - reg0 write in any state: loads ADDR immediately.
//     - In WR_WAIT: the write stays pending and goes to the new address; the MSB select follows the new ADDR.
//     - In IDLE, INC or RD_WAIT: go to RD_WAIT, with no increment of the new address.
//   - reg2 write: MOD <= CPU_DIN in any state; it takes effect at the next INC.
//   - Ack and new reg1 write in the same CLK: the ack completes the old data. The new data is latched and re-requested after INC. This costs 2 increments.
//  CPU reads:
//   - CPU_DOUT registered on CPU_RD_STB, 1 CLK latency; holds its value until the next read.
//   - A reg1 read returns the prefetch even while BUSY; stale data is accepted. Reads never increment.
//  Reset mid-operation: all state is cleared asynchronously and the request is released at once.
// STRUCTURE
//  Shared package lspc_pkg:
//   - REG_VRAMADDR=2'd0, REG_VRAMRW=2'd1, REG_VRAMMOD=2'd2.
//   - FSM state enum {IDLE, WR_WAIT, INC, RD_WAIT}.
//  Sub-module vram_addr_step: combinational next address from (addr, mod, PRESERVE_MSB).
//  Single always block for the FSM plus the register set; no other hierarchy.
// TESTING
//  1) MOD=1, ADDR=16'h7000, write reg1=16'hABCD, nCPU_WR_LOW pulse.
//     -> VRAM_WRITE=ABCD, request low until the ack, then ADDR=7001.
//  2) ADDR=16'h8000 (high), MOD=16'h0020, 3 writes, each acked on nCPU_WR_HIGH.
//     -> ADDR=8060; nCPU_WR_LOW pulses ignored throughout.
//  3) ADDR=16'h7FFF, MOD=1, PRESERVE_MSB=1, one write+ack -> ADDR=0000.
//     With PRESERVE_MSB=0 -> ADDR=8000.
//  4) ADDR=16'h0010, RD_LOW_STB with VRAM_LOW_READ=1234, then reg1 read.
//     -> CPU_DOUT=1234 one CLK after the read; ADDR stays 0010.
//  5) Two reg1 writes (1111 then 2222) before the ack.
//     -> the single committed word is 2222; ADDR advanced once.
//  6) RESETP low during WR_WAIT.
//     -> nVRAM_WRITE_REQ=1 and ADDR=0 immediately; a later ack pulse causes no increment.

Source files
------------

// File: rtl/lspc_pkg.sv
// Shared definitions for the LSPC VRAM CPU port: register indices as decoded
// from the 68k bus, and the state encoding of the CPU-side request FSM.
package lspc_pkg;

    localparam logic [1:0] REG_VRAMADDR = 2'd0;
    localparam logic [1:0] REG_VRAMRW   = 2'd1;
    localparam logic [1:0] REG_VRAMMOD  = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        WR_WAIT,
        INC,
        RD_WAIT
    } vram_state_t;

endpackage

// File: rtl/lspc_vram_cpu_port_addr_step.sv
// Auto-increment address calculator for the VRAM CPU port.
// Ports:
//   addr      in  16  current VRAM address
//   modulo    in  16  REG_VRAMMOD value
//   addr_next out 16  address after one increment
// PRESERVE_MSB=1 holds bit 15 (bank select) and wraps the low 15 bits;
// PRESERVE_MSB=0 performs a plain 16-bit add.
module vram_addr_step #(
    parameter bit PRESERVE_MSB = 1'b1
) (
    input  logic [15:0] addr,
    input  logic [15:0] modulo,
    output logic [15:0] addr_next
);

    always_comb begin
        addr_next = addr + modulo;
        if (PRESERVE_MSB) begin
            addr_next = {addr[15], addr[14:0] + modulo[14:0]};
        end
    end

endmodule

// File: rtl/lspc_vram_cpu_port.sv
// CPU-side initiator for the LSPC VRAM ports. Owns REG_VRAMADDR, REG_VRAMRW
// and REG_VRAMMOD, requests writes from the slow (low) / fast (high) cycle
// engines, applies the auto-increment and keeps a prefetched read word.
// Ports:
//   CLK, RESETP                 clock, asynchronous active-low reset
//   CPU_WR_STB/CPU_RD_STB       1-CLK register write/read pulses
//   CPU_REG, CPU_DIN, CPU_DOUT  register index, write data, read data
//   nVRAM_WRITE_REQ             low while a CPU write is pending
//   VRAM_ADDR, VRAM_WRITE       current address, latched write data
//   REG_VRAMADDR_MSB            VRAM_ADDR[15], 1 = fast/high VRAM
//   nCPU_WR_HIGH/nCPU_WR_LOW    write-taken acks from fast/slow cycles
//   RD_HIGH_STB/RD_LOW_STB      read word valid strobes
//   VRAM_HIGH_READ/VRAM_LOW_READ read words
//   BUSY                        FSM not in IDLE
module lspc_vram_cpu_port
    import lspc_pkg::*;
#(
    parameter bit          PRESERVE_MSB = 1'b1,
    parameter logic [15:0] RST_MOD      = 16'd1
) (
    input  logic        CLK,
    input  logic        RESETP,
    input  logic        CPU_WR_STB,
    input  logic        CPU_RD_STB,
    input  logic [1:0]  CPU_REG,
    input  logic [15:0] CPU_DIN,
    output logic [15:0] CPU_DOUT,
    output logic        nVRAM_WRITE_REQ,
    output logic [15:0] VRAM_ADDR,
    output logic [15:0] VRAM_WRITE,
    output logic        REG_VRAMADDR_MSB,
    input  logic        nCPU_WR_HIGH,
    input  logic        nCPU_WR_LOW,
    input  logic        RD_HIGH_STB,
    input  logic        RD_LOW_STB,
    input  logic [15:0] VRAM_HIGH_READ,
    input  logic [15:0] VRAM_LOW_READ,
    output logic        BUSY
);

    vram_state_t state;
    logic [15:0] modulo;
    logic [15:0] prefetch;
    logic [15:0] addr_next;
    logic        ack_high_q;
    logic        ack_low_q;
    logic        wr_pend;

    logic wr_addr;
    logic wr_rw;
    logic wr_mod;
    logic ack;
    logic rd_match;

    assign wr_addr = CPU_WR_STB && (CPU_REG == REG_VRAMADDR);
    assign wr_rw   = CPU_WR_STB && (CPU_REG == REG_VRAMRW);
    assign wr_mod  = CPU_WR_STB && (CPU_REG == REG_VRAMMOD);

    // Falling edge of the ack belonging to the bank currently addressed.
    assign ack = VRAM_ADDR[15] ? (ack_high_q && !nCPU_WR_HIGH)
                               : (ack_low_q  && !nCPU_WR_LOW);
    assign rd_match = VRAM_ADDR[15] ? RD_HIGH_STB : RD_LOW_STB;

    assign REG_VRAMADDR_MSB = VRAM_ADDR[15];
    assign BUSY             = (state != IDLE);

    vram_addr_step #(
        .PRESERVE_MSB(PRESERVE_MSB)
    ) u_step (
        .addr      (VRAM_ADDR),
        .modulo    (modulo),
        .addr_next (addr_next)
    );

    always_ff @(posedge CLK or negedge RESETP) begin
        if (!RESETP) begin
            state           <= IDLE;
            VRAM_ADDR       <= '0;
            VRAM_WRITE      <= '0;
            modulo          <= RST_MOD;
            prefetch        <= '0;
            CPU_DOUT        <= '0;
            nVRAM_WRITE_REQ <= 1'b1;
            ack_high_q      <= 1'b1;
            ack_low_q       <= 1'b1;
            wr_pend         <= 1'b0;
        end else begin
            ack_high_q <= nCPU_WR_HIGH;
            ack_low_q  <= nCPU_WR_LOW;

            if (CPU_RD_STB) begin
                case (CPU_REG)
                    REG_VRAMRW:  CPU_DOUT <= prefetch;
                    REG_VRAMMOD: CPU_DOUT <= modulo;
                    default:     CPU_DOUT <= '0;
                endcase
            end

            if (wr_mod) begin
                modulo <= CPU_DIN;
            end

            case (state)
                IDLE: begin
                    if (wr_rw) begin
                        VRAM_WRITE      <= CPU_DIN;
                        nVRAM_WRITE_REQ <= 1'b0;
                        state           <= WR_WAIT;
                    end else if (wr_addr) begin
                        VRAM_ADDR <= CPU_DIN;
                        state     <= RD_WAIT;
                    end
                end

                WR_WAIT: begin
                    if (wr_addr) begin
                        VRAM_ADDR <= CPU_DIN;
                    end
                    if (ack) begin
                        nVRAM_WRITE_REQ <= 1'b1;
                        state           <= INC;
                        // New data arriving with the ack is re-requested after INC.
                        if (wr_rw) begin
                            VRAM_WRITE <= CPU_DIN;
                            wr_pend    <= 1'b1;
                        end
                    end else if (wr_rw) begin
                        VRAM_WRITE <= CPU_DIN;
                    end
                end

                INC: begin
                    if (wr_addr) begin
                        VRAM_ADDR <= CPU_DIN;
                    end else begin
                        VRAM_ADDR <= addr_next;
                    end
                    if (wr_rw || wr_pend) begin
                        if (wr_rw) begin
                            VRAM_WRITE <= CPU_DIN;
                        end
                        wr_pend         <= 1'b0;
                        nVRAM_WRITE_REQ <= 1'b0;
                        state           <= WR_WAIT;
                    end else begin
                        state <= RD_WAIT;
                    end
                end

                RD_WAIT: begin
                    if (wr_rw) begin
                        VRAM_WRITE      <= CPU_DIN;
                        nVRAM_WRITE_REQ <= 1'b0;
                        state           <= WR_WAIT;
                    end else if (wr_addr) begin
                        VRAM_ADDR <= CPU_DIN;
                    end else if (rd_match) begin
                        prefetch <= VRAM_ADDR[15] ? VRAM_HIGH_READ : VRAM_LOW_READ;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
